// File: rtl/fd_pkg.sv
// Shared definitions for the fetch/decode unit: RV32I opcode and funct
// fields, ALU control encodings, FSM state encoding and an immediate helper.
package fd_pkg;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL     = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRL = 4'b1001;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_WRITEBACK = 3'd3,
      ST_HALT      = 3'd4
   } fd_state_t;

   // Sign-extended I-type immediate taken from instruction bits [31:20].
   function automatic logic [31:0] sext_i_imm(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[31:20]};
   endfunction

endpackage

// File: rtl/alu_ctrl_decoder.sv
// Combinational ALU control decoder: {opcode, funct3, funct7} ->
// {alu_control, legal}, plus is_imm for immediate-operand instructions.
// Optional feature macro: IMM_ADDI_EN (decode ADDI as a legal instruction).
module alu_ctrl_decoder
   import fd_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] alu_control,
   output logic       legal,
   output logic       is_imm
);

   // Map the supported R-type (and optionally ADDI) encodings to ALU selects.
   always_comb begin
      alu_control = ALU_AND;
      legal       = 1'b0;
      is_imm      = 1'b0;
      case (opcode)
         OP_R: begin
            case (funct3)
               F3_ADD_SUB: begin
                  if (funct7 == F7_BASE) begin
                     alu_control = ALU_ADD;
                     legal       = 1'b1;
                  end else if (funct7 == F7_SUB) begin
                     alu_control = ALU_SUB;
                     legal       = 1'b1;
                  end
               end
               F3_AND: begin alu_control = ALU_AND; legal = (funct7 == F7_BASE); end
               F3_OR:  begin alu_control = ALU_OR;  legal = (funct7 == F7_BASE); end
               F3_XOR: begin alu_control = ALU_XOR; legal = (funct7 == F7_BASE); end
               F3_SLT: begin alu_control = ALU_SLT; legal = (funct7 == F7_BASE); end
               F3_SLL: begin alu_control = ALU_SLL; legal = (funct7 == F7_BASE); end
               F3_SRL: begin alu_control = ALU_SRL; legal = (funct7 == F7_BASE); end
               default: legal = 1'b0;
            endcase
         end
`ifdef IMM_ADDI_EN
         OP_I: begin
            if (funct3 == F3_ADD_SUB) begin
               alu_control = ALU_ADD;
               legal       = 1'b1;
               is_imm      = 1'b1;
            end
         end
`endif
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/fetch_decode_unit.sv
// Multi-cycle fetch/decode/control stage: PC, writable instruction memory,
// instruction register and a FETCH/DECODE/EXECUTE/WRITEBACK FSM driving the
// register-file/ALU datapath controls.
// Optional feature macro: IMM_ADDI_EN (ADDI support with immediate operand).
module fetch_decode_unit
   import fd_pkg::*;
#(
   parameter int          IMEM_DEPTH = 64,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
)
(
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          stall,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
   input  logic [31:0]                   imem_wdata,
   output logic [31:0]                   pc,
   output logic [4:0]                    read_reg_num1,
   output logic [4:0]                    read_reg_num2,
   output logic [4:0]                    write_reg,
   output logic [3:0]                    alu_control,
   output logic                          regwrite,
   output logic                          alu_src_imm,
   output logic [31:0]                   imm,
   output logic                          halted,
   output logic                          illegal_instr
);

   localparam int AW = $clog2(IMEM_DEPTH);

   fd_state_t       state_reg, state_next;
   logic [31:0]     imem [IMEM_DEPTH];
   logic [31:0]     ir_reg;
   logic [31:0]     pc_reg;
   logic [AW-1:0]   pc_idx_next;
   logic [4:0]      rs1_reg, rs2_reg, rd_reg;
   logic [3:0]      alu_control_reg;
   logic            illegal_reg;
   logic [3:0]      dec_alu_control;
   logic            dec_legal, dec_is_imm;
   logic            fetch_en, decode_active, decode_ok, advance_pc;

   alu_ctrl_decoder u_alu_ctrl_decoder (
      .opcode      (ir_reg[6:0]),
      .funct3      (ir_reg[14:12]),
      .funct7      (ir_reg[31:25]),
      .alu_control (dec_alu_control),
      .legal       (dec_legal),
      .is_imm      (dec_is_imm)
   );

   assign fetch_en      = (state_reg == ST_FETCH) && !stall && !reset;
   assign decode_active = (state_reg == ST_DECODE) && !stall;
   assign decode_ok     = decode_active && (ir_reg != 32'h0) && dec_legal;
   assign advance_pc    = (state_reg == ST_WRITEBACK) && !stall;
   // Only the word index advances, so the PC wraps inside the memory.
   assign pc_idx_next   = pc_reg[AW+1:2] + {{(AW-1){1'b0}}, 1'b1};

   // Instruction memory: write port plus read-first registered fetch into IR.
   always_ff @(posedge clock) begin
      if (imem_we) begin
         imem[imem_waddr] <= imem_wdata;
      end
      if (fetch_en) begin
         ir_reg <= imem[pc_reg[AW+1:2]];
      end
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= ST_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and write strobe; stall or reset freezes progress.
   always_comb begin
      state_next = state_reg;
      regwrite   = 1'b0;
      if (!stall) begin
         case (state_reg)
            ST_FETCH:     state_next = ST_DECODE;
            ST_DECODE: begin
               if (ir_reg == 32'h0 || !dec_legal) begin
                  state_next = ST_HALT;
               end else begin
                  state_next = ST_EXECUTE;
               end
            end
            ST_EXECUTE:   state_next = ST_WRITEBACK;
            ST_WRITEBACK: begin
               state_next = ST_FETCH;
               regwrite   = !reset;
            end
            ST_HALT:      state_next = ST_HALT;
            default:      state_next = ST_FETCH;
         endcase
      end
   end

   // Program counter: advances once per completed writeback.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_reg <= RESET_PC;
      end else if (advance_pc) begin
         pc_reg <= {pc_reg[31:AW+2], pc_idx_next, 2'b00};
      end
   end

   // Decoded register numbers and ALU select, held until the next decode.
   always_ff @(posedge clock) begin
      if (reset) begin
         rs1_reg         <= 5'd0;
         rs2_reg         <= 5'd0;
         rd_reg          <= 5'd0;
         alu_control_reg <= 4'd0;
         illegal_reg     <= 1'b0;
      end else begin
         if (decode_ok) begin
            rs1_reg         <= ir_reg[19:15];
            rs2_reg         <= dec_is_imm ? 5'd0 : ir_reg[24:20];
            rd_reg          <= ir_reg[11:7];
            alu_control_reg <= dec_alu_control;
         end
         if (decode_active && (ir_reg != 32'h0) && !dec_legal) begin
            illegal_reg <= 1'b1;
         end
      end
   end

`ifdef IMM_ADDI_EN
   logic        alu_src_imm_reg;
   logic [31:0] imm_reg;

   // Immediate operand select and value, captured alongside the other fields.
   always_ff @(posedge clock) begin
      if (reset) begin
         alu_src_imm_reg <= 1'b0;
         imm_reg         <= 32'h0;
      end else if (decode_ok) begin
         alu_src_imm_reg <= dec_is_imm;
         imm_reg         <= sext_i_imm(ir_reg);
      end
   end

   assign alu_src_imm = alu_src_imm_reg;
   assign imm         = imm_reg;
`else
   assign alu_src_imm = 1'b0;
   assign imm         = 32'h0;
`endif

   assign pc            = pc_reg;
   assign read_reg_num1 = rs1_reg;
   assign read_reg_num2 = rs2_reg;
   assign write_reg     = rd_reg;
   assign alu_control   = alu_control_reg;
   assign halted        = (state_reg == ST_HALT);
   assign illegal_instr = illegal_reg;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit: directed scenarios plus random
// programs, checked by a scoreboard fed from an instruction-level model.
// Honours the IMM_ADDI_EN macro the same way as the design.
module tb_fetch_decode_unit;

   localparam int DEPTH = 64;
`ifdef IMM_ADDI_EN
   localparam bit ADDI_ON = 1'b1;
`else
   localparam bit ADDI_ON = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        imem_we = 1'b0;
   logic [5:0]  imem_waddr = 6'd0;
   logic [31:0] imem_wdata = 32'h0;
   logic [31:0] pc, imm;
   logic [4:0]  read_reg_num1, read_reg_num2, write_reg;
   logic [3:0]  alu_control;
   logic        regwrite, alu_src_imm, halted, illegal_instr;

   fetch_decode_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clock(clock), .reset(reset), .stall(stall), .imem_we(imem_we),
      .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .pc(pc),
      .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
      .write_reg(write_reg), .alu_control(alu_control), .regwrite(regwrite),
      .alu_src_imm(alu_src_imm), .imm(imm), .halted(halted),
      .illegal_instr(illegal_instr)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  alu;
      logic        src_imm;
      logic [31:0] imm;
   } txn_t;

   txn_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_txn = 0;
   logic [31:0] tb_mem [DEPTH];
   int          m_idx;
   bit          m_halted, m_illegal;
   bit          stall_rand = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   // Scoreboard monitor: every regwrite pulse must match the next expected instruction.
   always @(negedge clock) begin
      txn_t t;
      if (regwrite === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_regwrite: actual pulse at pc=%h required no pulse", pc);
         end else begin
            t = exp_q.pop_front();
            n_txn++;
            $display("txn %0d pc=%h rs1=%0d rs2=%0d rd=%0d alu=%b imm_sel=%0d",
                     n_txn, pc, read_reg_num1, read_reg_num2, write_reg, alu_control, alu_src_imm);
            check("wb_pc", pc, t.pc);
            check("wb_rs1", 32'(read_reg_num1), 32'(t.rs1));
            check("wb_rs2", 32'(read_reg_num2), 32'(t.rs2));
            check("wb_rd", 32'(write_reg), 32'(t.rd));
            check("wb_alu", 32'(alu_control), 32'(t.alu));
            check("wb_src_imm", 32'(alu_src_imm), 32'(t.src_imm));
            if (t.src_imm || !ADDI_ON) check("wb_imm", imm, t.imm);
         end
      end
   end

   // Random stall generator, active only while stall_rand is set.
   always @(posedge clock) begin
      #2;
      if (stall_rand) stall = ($urandom_range(0, 3) == 0);
   end

   task automatic model_reset();
      m_idx = 0;
      m_halted = 1'b0;
      m_illegal = 1'b0;
      exp_q.delete();
   endtask

   // Instruction-level reference: walk memory from the model PC, one entry per retired instruction.
   task automatic model_run(input int max_steps);
      int steps = 0;
      while (!m_halted && steps < max_steps) begin
         logic [31:0] w;
         logic [6:0]  op, f7;
         logic [2:0]  f3;
         int          code;
         bit          is_i;
         txn_t        t;
         w = tb_mem[m_idx];
         op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
         code = -1; is_i = 1'b0;
         if (w == 32'h0) begin
            m_halted = 1'b1;
         end else begin
            if (op == 7'h33) begin
               if (f3 == 3'd0 && f7 == 7'h00) code = 2;        // add
               else if (f3 == 3'd0 && f7 == 7'h20) code = 6;   // sub
               else if (f3 == 3'd7 && f7 == 7'h00) code = 0;   // and
               else if (f3 == 3'd6 && f7 == 7'h00) code = 1;   // or
               else if (f3 == 3'd4 && f7 == 7'h00) code = 3;   // xor
               else if (f3 == 3'd2 && f7 == 7'h00) code = 7;   // slt
               else if (f3 == 3'd1 && f7 == 7'h00) code = 8;   // sll
               else if (f3 == 3'd5 && f7 == 7'h00) code = 9;   // srl
            end else if (op == 7'h13 && f3 == 3'd0 && ADDI_ON) begin
               code = 2;                                       // addi
               is_i = 1'b1;
            end
            if (code < 0) begin
               m_halted = 1'b1;
               m_illegal = 1'b1;
            end else begin
               t.pc = 32'(m_idx * 4);
               t.rs1 = w[19:15];
               t.rs2 = is_i ? 5'd0 : w[24:20];
               t.rd = w[11:7];
               t.alu = 4'(code);
               t.src_imm = is_i;
               t.imm = is_i ? {{20{w[31]}}, w[31:20]} : 32'h0;
               exp_q.push_back(t);
               m_idx = (m_idx + 1) % DEPTH;
            end
         end
         steps++;
      end
   endtask

   function automatic logic [31:0] rand_instr(input bit legal_only);
      logic [4:0] rs1, rs2, rd;
      logic [2:0] f3;
      logic [6:0] f7, op;
      int         kind;
      rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      kind = legal_only ? 0 : int'($urandom_range(0, 15));
      f7 = 7'h00;
      op = 7'h33;
      f3 = 3'($urandom);
      if (kind < 11) begin
         if (f3 == 3'd3) f3 = 3'd7;
         if (f3 == 3'd0 && $urandom_range(0, 1) == 1) f7 = 7'h20;
      end else if (kind < 13) begin
         op = 7'h13;
         if ($urandom_range(0, 3) != 0) f3 = 3'd0;
         f7 = 7'($urandom);
      end else if (kind == 13) begin
         if ($urandom_range(0, 1) == 1) f3 = 3'd3;
         else begin f3 = 3'd5; f7 = 7'h20; end
      end else if (kind == 14) begin
         op = 7'($urandom) | 7'h01;
         if (op == 7'h33 || op == 7'h13) op = op ^ 7'h40;
      end else begin
         f3 = 3'd0; f7 = 7'h01;
      end
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   task automatic imem_write(input int a, input logic [31:0] d);
      imem_we = 1'b1;
      imem_waddr = 6'(a);
      imem_wdata = d;
      @(posedge clock); #1;
      imem_we = 1'b0;
   endtask

   task automatic load_program(input int n);
      for (int i = 0; i < n; i++) imem_write(i, tb_mem[i]);
   endtask

   // Waits (bounded) for halt, checks final architectural state, then re-enters reset.
   task automatic finish_run(input string tag, input int budget);
      int          c = 0;
      logic [31:0] pc_at_halt;
      while (halted !== 1'b1 && c < budget) begin
         @(posedge clock); #1;
         c++;
      end
      stall_rand = 1'b0;
      check({tag, "_halted"}, 32'(halted), 32'd1);
      check({tag, "_pc"}, pc, 32'(m_idx * 4));
      check({tag, "_illegal"}, 32'(illegal_instr), 32'(m_illegal));
      check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
      pc_at_halt = pc;
      repeat (3) begin @(posedge clock); #1; end
      stall = 1'b0;
      check({tag, "_halt_sticky"}, 32'(halted), 32'd1);
      check({tag, "_pc_frozen"}, pc, pc_at_halt);
      reset = 1'b1;
      @(posedge clock); #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: actual=timeout required=completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len;

      // Reset state.
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("rst_pc", pc, 32'h0);
      check("rst_regwrite", 32'(regwrite), 32'd0);
      check("rst_rs1", 32'(read_reg_num1), 32'd0);
      check("rst_rs2", 32'(read_reg_num2), 32'd0);
      check("rst_rd", 32'(write_reg), 32'd0);
      check("rst_alu", 32'(alu_control), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_illegal", 32'(illegal_instr), 32'd0);
      check("rst_src_imm", 32'(alu_src_imm), 32'd0);
      check("rst_imm", imm, 32'h0);

      // add x3,x1,x2 with cycle-exact timing, then halt.
      model_reset();
      tb_mem[0] = 32'h002081B3; tb_mem[1] = 32'h0;
      load_program(2);
      model_run(100);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("add_rs1", 32'(read_reg_num1), 32'd1);
      check("add_rs2", 32'(read_reg_num2), 32'd2);
      check("add_rd", 32'(write_reg), 32'd3);
      check("add_alu", 32'(alu_control), 32'h2);
      check("add_no_early_wr", 32'(regwrite), 32'd0);
      @(posedge clock); #1;
      check("add_regwrite", 32'(regwrite), 32'd1);
      @(posedge clock); #1;
      check("add_pc4", pc, 32'h4);
      check("add_regwrite_drop", 32'(regwrite), 32'd0);
      finish_run("add", 200);

      // sub, and, halt.
      model_reset();
      tb_mem[0] = 32'h40208233; tb_mem[1] = 32'h0020F2B3; tb_mem[2] = 32'h0;
      load_program(3);
      model_run(100);
      reset = 1'b0;
      finish_run("sub_and", 200);

      // Stall held for 5 cycles in WRITEBACK.
      model_reset();
      tb_mem[0] = 32'h002081B3; tb_mem[1] = 32'h0020F2B3; tb_mem[2] = 32'h0;
      load_program(3);
      model_run(100);
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      stall = 1'b1;
      repeat (5) begin
         @(negedge clock);
         check("stall_regwrite", 32'(regwrite), 32'd0);
         check("stall_pc", pc, 32'h0);
      end
      @(posedge clock); #1;
      stall = 1'b0;
      @(negedge clock);
      check("stall_resume_wr", 32'(regwrite), 32'd1);
      @(posedge clock); #1;
      check("stall_resume_pc", pc, 32'h4);
      finish_run("stall", 200);

      // addi x1,x0,5: legal with the immediate feature, illegal otherwise.
      model_reset();
      tb_mem[0] = 32'h00500093; tb_mem[1] = 32'h0;
      load_program(2);
      model_run(100);
      reset = 1'b0;
      finish_run("addi", 200);

      // Reset asserted during EXECUTE abandons the instruction.
      model_reset();
      tb_mem[0] = 32'h002081B3; tb_mem[1] = 32'h40208233; tb_mem[2] = 32'h0;
      load_program(3);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      check("midrst_pc", pc, 32'h0);
      check("midrst_regwrite", 32'(regwrite), 32'd0);
      check("midrst_rs1", 32'(read_reg_num1), 32'd0);
      check("midrst_halted", 32'(halted), 32'd0);
      model_run(100);
      reset = 1'b0;
      finish_run("midrst", 200);

      // Full memory of legal instructions: PC wraps to 0, then a patched halt at word 1.
      model_reset();
      for (int i = 0; i < DEPTH; i++) tb_mem[i] = rand_instr(1'b1);
      load_program(DEPTH);
      model_run(DEPTH);
      tb_mem[1] = 32'h0;
      model_run(10);
      reset = 1'b0;
      begin
         int c = 0;
         while (exp_q.size() > DEPTH + 1 - 5 && c < 1000) begin
            @(posedge clock); #1;
            c++;
         end
         check("wrap_progress", 32'(exp_q.size() <= DEPTH + 1 - 5), 32'd1);
      end
      imem_write(1, 32'h0);
      finish_run("wrap", 2000);

      // Random programs with random stalls.
      for (int r = 0; r < 12; r++) begin
         model_reset();
         len = int'($urandom_range(3, 20));
         for (int i = 0; i < len; i++) tb_mem[i] = rand_instr(1'b0);
         tb_mem[len] = 32'h0;
         load_program(len + 1);
         model_run(100);
         stall_rand = 1'b1;
         reset = 1'b0;
         finish_run("rand", 3000);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
